rgmii_tx_ddr_prep: RTL and testbench
====================================

// Module: rgmii_tx_ddr_prep
// PURPOSE
//  Transmit-side stage upstream of the generic ODDR. Converts a GMII byte stream
//  (txd/tx_en/tx_er) into per-cycle rising/falling-half (d1/d2) pairs that drive the
//  ODDR data, ctl and forwarded-clock lanes.
//  Supports 1000/100/10 Mb/s from a single 125 MHz clock and paces the MAC
//  with a byte strobe at 10/100 Mb/s.
// PARAMETERS
//  DIV_100M  5   cycles per nibble period at 100M (>=2; odd values allowed)
//  DIV_10M   50  cycles per nibble period at 10M (>=2, <=64)
// PORTS
//  clk           in   1  125 MHz TX clock; also clocks the downstream ODDR
//  rst_n         in   1  asynchronous reset, active low
//  speed         in   2  00=10M, 01=100M, 1x=1000M; quasi-static
//  gmii_txd      in   8  byte from MAC; sampled on clk edges where gmii_clk_en=1
//  gmii_tx_en    in   1  frame valid, sampled with gmii_txd
//  gmii_tx_er    in   1  error, sampled with gmii_txd
//  gmii_clk_en   out  1  byte strobe to MAC (registered)
//  txd_d1        out  4  RGMII data, rising half
//  txd_d2        out  4  RGMII data, falling half
//  ctl_d1        out  1  RGMII ctl, rising half (=tx_en)
//  ctl_d2        out  1  RGMII ctl, falling half (=tx_en^tx_er)
//  clk_d1        out  1  forwarded TXC, rising half
//  clk_d2        out  1  forwarded TXC, falling half
// BEHAVIOUR
//  - Reset: every output 0. Internal state is cnt=0, phase=0 and a hold byte of 0 with en=er=0.
//    Reset is async assert; deassertion is synchronous to clk.
//  - All outputs are registered. A byte sampled at edge E appears on the d1/d2 outputs in the cycle after E.
//  - 1000M:
//    - gmii_clk_en=1 in every cycle from the first edge after reset release.
//    - Per cycle: txd_d1=txd[3:0], txd_d2=txd[7:4], ctl_d1=en, ctl_d2=en^er.
//    - clk_d1=1 and clk_d2=0 constantly.
//  - 10/100 (N=DIV_10M or DIV_100M):
//    - Counter cnt runs 0..N-1; the nibble flag phase toggles at each edge where cnt=N-1.
//    - gmii_clk_en=1 only in the cycle where cnt=N-1 and phase=1, i.e. one cycle every 2N cycles.
//    - At that edge the byte is captured into the hold register and the low nibble is launched.
//    - At the edge where cnt=N-1 and phase=0, the high nibble is launched.
//    - During a nibble period: txd_d1=txd_d2=nibble, ctl_d1=en, ctl_d2=en^er. Held for all N cycles.
//    - Clock pattern, cycle k of the nibble period:
//      - k < floor(N/2): (1,1).
//      - k = floor(N/2) when N is odd: (1,0).
//      - otherwise: (0,0).
//      - Example, N=5: 11,11,10,00,00.
//    - The TXC rising edge coincides with the nibble launch (edge-aligned; skew is added downstream).
//    - After reset, the first nibble periods output idle. The first gmii_clk_en pulse occurs in cycle 2N-1 after reset release.
//  - Speed change:
//    - A registered compare detects the change.
//    - On the next edge: cnt=0, phase=0, hold cleared to idle (en=er=0), gmii_clk_en=0.
//    - The new rate starts from there; any byte in flight is dropped.
//    - The MAC changes speed only between frames.
//  - Reset mid-byte: outputs go to 0 immediately; no partial nibble is emitted after release.
//  - gmii inputs are ignored in cycles where gmii_clk_en=0.
// TESTING
//  1. 1000M: txd=A5, en=1, er=0 at edge E -> cycle E+1: txd_d1=5, txd_d2=A, ctl=11, clk=10.
//  2. 1000M: en=1, er=1, txd=FF -> ctl_d1=1, ctl_d2=0. Then en=0, er=1 -> ctl=01 (carrier-extend code).
//  3. 100M: gmii_clk_en period 10 cycles. Byte 3C -> txd=C,C for 5 cycles, then 3,3 for 5 cycles.
//     ctl=11 throughout; clk pattern 11,11,10,00,00 repeating.
//  4. 10M: gmii_clk_en period 100 cycles. Clock (1,1) for 25 cycles then (0,0) for 25.
//     8-byte frame reproduces all nibbles in order, low nibble first.
//  5. Switch speed 01->10 in mid-byte -> next edge idle. gmii_clk_en=1 every cycle from the following edge.
//     No stale nibble appears.
//  6. Assert rst_n=0 mid-nibble at 10M -> all outputs 0 without waiting for a clk edge.
//     After release, first gmii_clk_en at cycle 99.

Source files
------------

// File: rtl/rgmii_tx_ddr_prep.sv
// GMII-to-RGMII transmit preparation: turns a MAC byte stream into rising/falling
// half pairs for the data, ctl and forwarded-clock ODDRs at 1000/100/10 Mb/s.
module rgmii_tx_ddr_prep #(
  parameter int DIV_100M = 5,
  parameter int DIV_10M  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       gmii_clk_en,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       ctl_d1,
  output logic       ctl_d2,
  output logic       clk_d1,
  output logic       clk_d2
);

  localparam int NMAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
  localparam int CW   = $clog2(NMAX + 1);
  localparam logic [CW-1:0] N100 = CW'(DIV_100M);
  localparam logic [CW-1:0] N10  = CW'(DIV_10M);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          phase_reg, phase_next;
  logic [7:0]    hold_d_reg;
  logic          hold_en_reg, hold_er_reg;
  logic [1:0]    speed_q_reg;
  logic          speed_vld_reg;

  logic [CW-1:0] n_sel, n_last, n_half;
  logic          gig, chg, last;
  logic          clk_en_next, clk_d1_next, clk_d2_next;

  always_comb begin
    gig    = speed[1];
    n_sel  = speed[0] ? N100 : N10;
    n_last = n_sel - 1'b1;
    n_half = n_sel >> 1;
    // speed_vld_reg keeps the first edge after reset from looking like a speed change
    chg    = speed_vld_reg && (speed != speed_q_reg);
    last   = (cnt_reg >= n_last);

    cnt_next   = '0;
    phase_next = 1'b0;
    if (!chg && !gig) begin
      cnt_next   = last ? '0 : cnt_reg + 1'b1;
      phase_next = last ? ~phase_reg : phase_reg;
    end

    // TXC shape for the cycle being entered; odd N gets a half-high middle cycle
    clk_d1_next = 1'b0;
    clk_d2_next = 1'b0;
    if (gig) begin
      clk_d1_next = 1'b1;
    end else if (cnt_next < n_half) begin
      clk_d1_next = 1'b1;
      clk_d2_next = 1'b1;
    end else if (n_sel[0] && (cnt_next == n_half)) begin
      clk_d1_next = 1'b1;
    end

    clk_en_next = !chg && (gig || ((cnt_next == n_last) && phase_next));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      phase_reg     <= 1'b0;
      hold_d_reg    <= 8'h00;
      hold_en_reg   <= 1'b0;
      hold_er_reg   <= 1'b0;
      speed_q_reg   <= 2'b00;
      speed_vld_reg <= 1'b0;
      gmii_clk_en   <= 1'b0;
      txd_d1        <= 4'h0;
      txd_d2        <= 4'h0;
      ctl_d1        <= 1'b0;
      ctl_d2        <= 1'b0;
      clk_d1        <= 1'b0;
      clk_d2        <= 1'b0;
    end else begin
      speed_vld_reg <= 1'b1;
      speed_q_reg   <= speed;
      cnt_reg       <= cnt_next;
      phase_reg     <= phase_next;
      gmii_clk_en   <= clk_en_next;
      clk_d1        <= clk_d1_next;
      clk_d2        <= clk_d2_next;

      if (chg) begin
        // drop whatever byte was in flight and restart idle at the new rate
        hold_d_reg  <= 8'h00;
        hold_en_reg <= 1'b0;
        hold_er_reg <= 1'b0;
        txd_d1      <= 4'h0;
        txd_d2      <= 4'h0;
        ctl_d1      <= 1'b0;
        ctl_d2      <= 1'b0;
      end else if (gig) begin
        if (gmii_clk_en) begin
          txd_d1 <= gmii_txd[3:0];
          txd_d2 <= gmii_txd[7:4];
          ctl_d1 <= gmii_tx_en;
          ctl_d2 <= gmii_tx_en ^ gmii_tx_er;
        end else begin
          txd_d1 <= 4'h0;
          txd_d2 <= 4'h0;
          ctl_d1 <= 1'b0;
          ctl_d2 <= 1'b0;
        end
      end else if (last) begin
        if (phase_reg) begin
          if (gmii_clk_en) begin
            hold_d_reg  <= gmii_txd;
            hold_en_reg <= gmii_tx_en;
            hold_er_reg <= gmii_tx_er;
            txd_d1      <= gmii_txd[3:0];
            txd_d2      <= gmii_txd[3:0];
            ctl_d1      <= gmii_tx_en;
            ctl_d2      <= gmii_tx_en ^ gmii_tx_er;
          end else begin
            txd_d1 <= 4'h0;
            txd_d2 <= 4'h0;
            ctl_d1 <= 1'b0;
            ctl_d2 <= 1'b0;
          end
        end else begin
          txd_d1 <= hold_d_reg[7:4];
          txd_d2 <= hold_d_reg[7:4];
          ctl_d1 <= hold_en_reg;
          ctl_d2 <= hold_en_reg ^ hold_er_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgmii_tx_ddr_prep.sv
// Directed bench for rgmii_tx_ddr_prep: 1000M vector table plus hand sequences
// for 100M/10M nibble pacing, speed changes and asynchronous reset.
module tb_rgmii_tx_ddr_prep;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] speed;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       gmii_clk_en;
  logic [3:0] txd_d1, txd_d2;
  logic       ctl_d1, ctl_d2, clk_d1, clk_d2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rgmii_tx_ddr_prep #(.DIV_100M(5), .DIV_10M(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .speed      (speed),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .gmii_clk_en(gmii_clk_en),
    .txd_d1     (txd_d1),
    .txd_d2     (txd_d2),
    .ctl_d1     (ctl_d1),
    .ctl_d2     (ctl_d2),
    .clk_d1     (clk_d1),
    .clk_d2     (clk_d2)
  );

  always #4 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within 200 us");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] txd;
    logic       en;
    logic       er;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       c1;
    logic       c2;
  } vec_t;

  vec_t vecs[6];

  // {txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2, gmii_clk_en}
  function automatic logic [12:0] pk(logic [3:0] d1, logic [3:0] d2, logic c1, logic c2,
                                     logic k1, logic k2, logic en);
    return {d1, d2, c1, c2, k1, k2, en};
  endfunction

  function automatic logic [12:0] dut_word();
    return {txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2, gmii_clk_en};
  endfunction

  function automatic logic [1:0] clk_exp(int k, int n);
    if (k < n / 2) return 2'b11;
    if ((n % 2 == 1) && (k == n / 2)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got=%h expected=%h", name, got, exp);
  endtask

  task automatic drive(input logic [7:0] b, input logic en, input logic er);
    gmii_txd   = b;
    gmii_tx_en = en;
    gmii_tx_er = er;
  endtask

  // Called at a negedge in the first cycle of a fresh count; waits for the byte strobe.
  task automatic wait_en(input int budget, input int exp_cycles, input string name);
    int  n = 0;
    bit  dirty = 0;
    while (!gmii_clk_en && n < budget) begin
      @(negedge clk);
      n++;
      if (gmii_clk_en == 1'b0 && (txd_d1 != 0 || txd_d2 != 0 || ctl_d1 || ctl_d2)) dirty = 1;
    end
    check({name, "_first_strobe_cycle"}, n, exp_cycles);
    check({name, "_idle_before_strobe"}, {31'd0, dirty}, 32'd0);
    $display("txn %s: first strobe after %0d cycles", name, n);
  endtask

  // Called at a negedge where gmii_clk_en=1; checks both nibble periods of the byte.
  task automatic run_byte(input logic [7:0] b, input logic en, input logic er, input int n,
                          input string name);
    int         bad = 0;
    logic [3:0] nib;
    logic [1:0] ck;
    drive(b, en, er);
    for (int i = 1; i <= 2 * n; i++) begin
      @(negedge clk);
      if (i == 1) drive(~b, ~en, er);
      nib = (i <= n) ? b[3:0] : b[7:4];
      ck  = clk_exp((i - 1) % n, n);
      total_cnt++;
      if (dut_word() === pk(nib, nib, en, en ^ er, ck[1], ck[0], i == 2 * n)) pass_cnt++;
      else begin
        bad++;
        $display("FAIL %s byte %h cycle %0d: got=%h expected=%h", name, b, i, dut_word(),
                 pk(nib, nib, en, en ^ er, ck[1], ck[0], i == 2 * n));
      end
    end
    $display("txn %s byte=%h en=%b er=%b N=%0d bad_cycles=%0d", name, b, en, er, n, bad);
  endtask

  logic [7:0] frame[8];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 4'h5, 4'hA, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 4'hC, 4'h3, 1'b1, 1'b1};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 4'h1, 4'h8, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    frame[0] = 8'h55; frame[1] = 8'h55; frame[2] = 8'hD5; frame[3] = 8'h01;
    frame[4] = 8'h23; frame[5] = 8'h45; frame[6] = 8'h67; frame[7] = 8'h89;

    rst_n = 1'b0;
    speed = 2'b10;
    drive(8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_outputs", {19'd0, dut_word()}, 32'd0);
    rst_n = 1'b1;

    // 1000M
    @(negedge clk);
    check("gig_first_edge", {19'd0, dut_word()}, {19'd0, pk(4'h0, 4'h0, 0, 0, 1, 0, 1)});
    foreach (vecs[v]) begin
      drive(vecs[v].txd, vecs[v].en, vecs[v].er);
      @(negedge clk);
      check($sformatf("gig_vec%0d", v), {19'd0, dut_word()},
            {19'd0, pk(vecs[v].d1, vecs[v].d2, vecs[v].c1, vecs[v].c2, 1, 0, 1)});
      $display("txn gig txd=%h en=%b er=%b -> d1=%h d2=%h ctl=%b%b", vecs[v].txd, vecs[v].en,
               vecs[v].er, txd_d1, txd_d2, ctl_d1, ctl_d2);
    end

    // 100M
    speed = 2'b01;
    @(negedge clk);
    check("chg_to_100", {19'd0, dut_word()}, {19'd0, pk(4'h0, 4'h0, 0, 0, 1, 1, 0)});
    wait_en(40, 9, "m100");
    run_byte(8'h3C, 1'b1, 1'b0, 5, "m100");
    run_byte(8'hA7, 1'b1, 1'b1, 5, "m100");
    run_byte(8'h00, 1'b0, 1'b0, 5, "m100");

    // 100M -> 1000M mid-byte; the high nibble 9 must never appear
    drive(8'h96, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_byte_low_nibble", {24'd0, txd_d1, txd_d2}, 32'h66);
    speed = 2'b10;
    drive(8'hEE, 1'b1, 1'b0);
    @(negedge clk);
    check("chg_to_gig_idle", {19'd0, dut_word()}, {19'd0, pk(4'h0, 4'h0, 0, 0, 1, 0, 0)});
    @(negedge clk);
    check("gig_resume_idle", {19'd0, dut_word()}, {19'd0, pk(4'h0, 4'h0, 0, 0, 1, 0, 1)});
    drive(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    check("gig_after_chg", {19'd0, dut_word()}, {19'd0, pk(4'hA, 4'h5, 1, 1, 1, 0, 1)});
    drive(8'h00, 1'b0, 1'b0);

    // 10M
    speed = 2'b00;
    @(negedge clk);
    check("chg_to_10", {19'd0, dut_word()}, {19'd0, pk(4'h0, 4'h0, 0, 0, 1, 1, 0)});
    wait_en(150, 99, "m10");
    foreach (frame[f]) run_byte(frame[f], 1'b1, 1'b0, 50, "m10_frame");
    run_byte(8'h00, 1'b0, 1'b0, 50, "m10_idle");

    // asynchronous reset in the middle of a nibble
    drive(8'hC3, 1'b1, 1'b0);
    repeat (60) @(negedge clk);
    check("pre_reset_high_nibble", {24'd0, txd_d1, txd_d2}, 32'hCC);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {19'd0, dut_word()}, 32'd0);
    repeat (3) @(negedge clk);
    check("reset_held_outputs", {19'd0, dut_word()}, 32'd0);
    rst_n = 1'b1;
    wait_en(150, 99, "m10_after_reset");
    run_byte(8'h4B, 1'b1, 1'b0, 50, "m10_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
